// File: rtl/fs_request_bridge_if.sv
// Signal bundle between the paged-RAM filesystem port, the bridge and the backing store.
// The slave modport is the bridge's view; the master modport is the environment driving it.
interface fs_request_bridge_if;
  logic [31:0] fsFilename;
  logic [31:0] fsAddress;
  logic [31:0] fsData;
  logic        fsRden;
  logic        fsWren;
  logic [31:0] fsQ;
  logic        fsQValid;
  logic        fsBusy;
  logic        fsErr;
  logic [1:0]  fileSel;
  logic        bkReqValid;
  logic        bkReqReady;
  logic        bkWe;
  logic [1:0]  bkFile;
  logic [31:0] bkAddr;
  logic [31:0] bkWdata;
  logic        bkRvalid;
  logic [31:0] bkRdata;

  modport master (
    output fsFilename, fsAddress, fsData, fsRden, fsWren,
    input  fsQ, fsQValid, fsBusy, fsErr, fileSel,
    input  bkReqValid, bkWe, bkFile, bkAddr, bkWdata,
    output bkReqReady, bkRvalid, bkRdata
  );

  modport slave (
    input  fsFilename, fsAddress, fsData, fsRden, fsWren,
    output fsQ, fsQValid, fsBusy, fsErr, fileSel,
    output bkReqValid, bkWe, bkFile, bkAddr, bkWdata,
    input  bkReqReady, bkRvalid, bkRdata
  );
endinterface

// File: rtl/fs_request_bridge.sv
// Filesystem-port to backing-store bridge: path decode, posted-write FIFO and a
// read FSM that issues reads only after all earlier writes have drained.
module fs_request_bridge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fs_request_bridge_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] C_DEV  = 32'h2F64_6576;
  localparam logic [31:0] C_MEM  = 32'h2F6D_656D;
  localparam logic [31:0] C_META = 32'h6D65_7461;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_chunk [3];
  logic [1:0]  r_chunk_cnt;
  logic        r_ovf;
  logic [1:0]  r_file_sel;
  logic [31:0] r_fs_q;
  logic        r_fs_qvalid;
  logic        r_fs_err;
  logic [1:0]  r_rd_file;
  logic [31:0] r_rd_addr;
  logic [1:0]  r_fifo_file [FIFO_DEPTH];
  logic [31:0] r_fifo_addr [FIFO_DEPTH];
  logic [31:0] r_fifo_data [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic        w_chunk_nz, w_commit, w_empty, w_full, w_idle;
  logic        w_req_err, w_wr_ok, w_rd_ok, w_push, w_pop, w_rd_start;
  logic [1:0]  w_new_sel, w_eff_file;
  logic        w_bk_valid, w_bk_we;
  logic [1:0]  w_bk_file;
  logic [31:0] w_bk_addr, w_bk_wdata;

  function automatic logic [1:0] decode_path(input logic [31:0] c0, input logic [31:0] c1,
                                             input logic [31:0] c2, input logic [1:0] cnt,
                                             input logic ovf);
    logic [1:0] sel;
    sel = 2'd0;
    if (!ovf && (c0 == C_DEV) && (c1 == C_MEM)) begin
      if (cnt == 2'd2) begin
        sel = 2'd1;
      end else if ((cnt == 2'd3) && (c2 == C_META)) begin
        sel = 2'd2;
      end else begin
        sel = 2'd0;
      end
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  assign w_chunk_nz = |bus.fsFilename;
  assign w_commit   = !w_chunk_nz && (r_chunk_cnt != 2'd0);
  assign w_new_sel  = decode_path(r_chunk[0], r_chunk[1], r_chunk[2], r_chunk_cnt, r_ovf);
  // A request in the commit cycle already targets the file being opened.
  assign w_eff_file = w_commit ? w_new_sel : r_file_sel;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_idle     = (r_state == ST_IDLE);

  assign w_req_err  = (bus.fsRden && bus.fsWren) ||
                      ((bus.fsRden || bus.fsWren) && (w_eff_file == 2'd0));
  assign w_wr_ok    = bus.fsWren && !w_req_err;
  assign w_rd_ok    = bus.fsRden && !w_req_err;
  assign w_push     = w_wr_ok && !w_full && w_idle;
  assign w_rd_start = w_rd_ok && w_empty && w_idle;
  assign w_pop      = w_idle && !w_empty && bus.bkReqReady;

  // Path chunk assembly and committed file selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chunk     <= '{32'd0, 32'd0, 32'd0};
      r_chunk_cnt <= 2'd0;
      r_ovf       <= 1'b0;
      r_file_sel  <= 2'd0;
    end else if (w_chunk_nz) begin
      if (r_chunk_cnt < 2'd3) begin
        r_chunk[r_chunk_cnt] <= bus.fsFilename;
        r_chunk_cnt          <= r_chunk_cnt + 2'd1;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (w_commit) begin
      r_chunk     <= '{32'd0, 32'd0, 32'd0};
      r_chunk_cnt <= 2'd0;
      r_ovf       <= 1'b0;
      r_file_sel  <= w_new_sel;
    end
  end

  // Posted-write FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Posted-write FIFO storage; entries keep the file tag they were written with.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_file[r_wptr[AW-1:0]] <= w_eff_file;
      r_fifo_addr[r_wptr[AW-1:0]] <= bus.fsAddress;
      r_fifo_data[r_wptr[AW-1:0]] <= bus.fsData;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Read FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_state_nxt = w_rd_start    ? ST_RD_REQ : ST_IDLE;
      ST_RD_REQ:  w_state_nxt = bus.bkReqReady ? ST_RD_WAIT : ST_RD_REQ;
      ST_RD_WAIT: w_state_nxt = bus.bkRvalid  ? ST_IDLE : ST_RD_WAIT;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Read request capture, read data return and error strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_file   <= 2'd0;
      r_rd_addr   <= 32'd0;
      r_fs_q      <= 32'd0;
      r_fs_qvalid <= 1'b0;
      r_fs_err    <= 1'b0;
    end else begin
      if (w_rd_start) begin
        r_rd_file <= w_eff_file;
        r_rd_addr <= bus.fsAddress;
      end
      r_fs_qvalid <= (r_state == ST_RD_WAIT) && bus.bkRvalid;
      if ((r_state == ST_RD_WAIT) && bus.bkRvalid) r_fs_q <= bus.bkRdata;
      r_fs_err    <= w_req_err;
    end
  end

  // Backing request mux: FIFO head while idle, latched read in RD_REQ.
  always_comb begin
    w_bk_valid = 1'b0;
    w_bk_we    = 1'b0;
    w_bk_file  = 2'd0;
    w_bk_addr  = 32'd0;
    w_bk_wdata = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_bk_valid = 1'b1;
          w_bk_we    = 1'b1;
          w_bk_file  = r_fifo_file[r_rptr[AW-1:0]];
          w_bk_addr  = r_fifo_addr[r_rptr[AW-1:0]];
          w_bk_wdata = r_fifo_data[r_rptr[AW-1:0]];
        end else begin
          w_bk_valid = 1'b0;
        end
      end
      ST_RD_REQ: begin
        w_bk_valid = 1'b1;
        w_bk_file  = r_rd_file;
        w_bk_addr  = r_rd_addr;
      end
      default: w_bk_valid = 1'b0;
    endcase
  end

  assign bus.fsBusy     = (w_wr_ok && (w_full || !w_idle)) || (w_rd_ok && (!w_empty || !w_idle));
  assign bus.fsQ        = r_fs_q;
  assign bus.fsQValid   = r_fs_qvalid;
  assign bus.fsErr      = r_fs_err;
  assign bus.fileSel    = r_file_sel;
  assign bus.bkReqValid = w_bk_valid;
  assign bus.bkWe       = w_bk_we;
  assign bus.bkFile     = w_bk_file;
  assign bus.bkAddr     = w_bk_addr;
  assign bus.bkWdata    = w_bk_wdata;

endmodule

// File: tb/tb_fs_request_bridge.sv
// Directed self-checking bench for fs_request_bridge: path decode, posted writes,
// read-after-write ordering, request errors and reset during an outstanding read.
module tb_fs_request_bridge;

  localparam logic [31:0] C_DEV  = 32'h2F64_6576;
  localparam logic [31:0] C_MEM  = 32'h2F6D_656D;
  localparam logic [31:0] C_META = 32'h6D65_7461;
  localparam logic [31:0] C_XYZ  = 32'h2F78_797A;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fs_request_bridge_if bus ();

  fs_request_bridge #(.FIFO_DEPTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0]  log_file [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  // Records every accepted backing write.
  always @(posedge clk) begin
    if (rst_n && bus.bkReqValid && bus.bkReqReady && bus.bkWe) begin
      log_file.push_back(bus.bkFile);
      log_addr.push_back(bus.bkAddr);
      log_data.push_back(bus.bkWdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chunk(input logic [31:0] c);
    bus.fsFilename = c;
    step();
  endtask

  task automatic clear_log();
    log_file.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.fsFilename = 32'd0;
    bus.fsAddress  = 32'd0;
    bus.fsData     = 32'd0;
    bus.fsRden     = 1'b0;
    bus.fsWren     = 1'b0;
    bus.bkReqReady = 1'b0;
    bus.bkRvalid   = 1'b0;
    bus.bkRdata    = 32'd0;
    repeat (3) step();

    check("rst_fsQ",        bus.fsQ, 32'd0);
    check("rst_fsQValid",   32'(bus.fsQValid), 32'd0);
    check("rst_fsErr",      32'(bus.fsErr), 32'd0);
    check("rst_fileSel",    32'(bus.fileSel), 32'd0);
    check("rst_bkReqValid", 32'(bus.bkReqValid), 32'd0);
    check("rst_bkAddr",     bus.bkAddr, 32'd0);
    check("rst_bkWdata",    bus.bkWdata, 32'd0);
    check("rst_fsBusy",     32'(bus.fsBusy), 32'd0);
    rst_n = 1'b1;
    step();

    // Path decode
    chunk(C_DEV); chunk(C_MEM); chunk(32'd0);
    check("open_mem", 32'(bus.fileSel), 32'd1);
    chunk(C_DEV); chunk(C_MEM); chunk(C_META); chunk(32'd0);
    check("open_meta", 32'(bus.fileSel), 32'd2);
    chunk(C_DEV); chunk(C_XYZ); chunk(32'd0);
    check("open_bad", 32'(bus.fileSel), 32'd0);
    chunk(C_DEV); chunk(C_MEM); chunk(C_DEV); chunk(C_MEM); chunk(32'd0);
    check("open_ovf", 32'(bus.fileSel), 32'd0);

    // Write with no open file is dropped
    clear_log();
    bus.fsWren = 1'b1; bus.fsAddress = 32'h5; bus.fsData = 32'h55;
    #1;
    check("nofile_busy", 32'(bus.fsBusy), 32'd0);
    step();
    bus.fsWren = 1'b0;
    check("nofile_err", 32'(bus.fsErr), 32'd1);
    check("nofile_bkvalid", 32'(bus.bkReqValid), 32'd0);
    step();
    check("nofile_err_clr", 32'(bus.fsErr), 32'd0);
    check("nofile_log", 32'(log_addr.size()), 32'd0);

    // Posted writes with backing store stalled
    chunk(C_DEV); chunk(C_MEM); chunk(32'd0);
    clear_log();
    for (int i = 0; i < 4; i++) begin
      bus.fsWren = 1'b1; bus.fsAddress = 32'h10 + i; bus.fsData = 32'hA0 + i;
      #1;
      check("post_busy", 32'(bus.fsBusy), 32'd0);
      step();
    end
    bus.fsAddress = 32'h14; bus.fsData = 32'hA4;
    #1;
    check("full_busy", 32'(bus.fsBusy), 32'd1);
    check("head_valid", 32'(bus.bkReqValid), 32'd1);
    check("head_addr", bus.bkAddr, 32'h10);
    step();
    bus.fsWren = 1'b0;
    bus.bkReqReady = 1'b1;
    repeat (4) step();
    check("drain_valid", 32'(bus.bkReqValid), 32'd0);
    check("drain_count", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check("drain_addr", log_addr[i], 32'h10 + i);
      check("drain_data", log_data[i], 32'hA0 + i);
      check("drain_file", 32'(log_file[i]), 32'd1);
    end

    // Read after write
    clear_log();
    bus.fsWren = 1'b1; bus.fsAddress = 32'h20; bus.fsData = 32'hDEAD_BEEF;
    step();
    bus.fsWren = 1'b0; bus.fsRden = 1'b1;
    #1;
    check("raw_busy_fifo", 32'(bus.fsBusy), 32'd1);
    check("raw_bkwe_wr", 32'(bus.bkWe), 32'd1);
    step();
    check("raw_busy_drained", 32'(bus.fsBusy), 32'd0);
    step();
    check("raw_busy_rdreq", 32'(bus.fsBusy), 32'd1);
    check("raw_bkwe_rd", 32'(bus.bkWe), 32'd0);
    check("raw_bkaddr_rd", bus.bkAddr, 32'h20);
    check("raw_bkvalid_rd", 32'(bus.bkReqValid), 32'd1);
    step();
    bus.bkRvalid = 1'b1; bus.bkRdata = 32'hDEAD_BEEF;
    #1;
    check("raw_busy_wait", 32'(bus.fsBusy), 32'd1);
    check("raw_qvalid_early", 32'(bus.fsQValid), 32'd0);
    step();
    bus.bkRvalid = 1'b0; bus.fsRden = 1'b0;
    check("raw_qvalid", 32'(bus.fsQValid), 32'd1);
    check("raw_q", bus.fsQ, 32'hDEAD_BEEF);
    check("raw_wr_first", 32'(log_data.size()), 32'd1);
    step();
    check("raw_qvalid_pulse", 32'(bus.fsQValid), 32'd0);

    // Stray response outside RD_WAIT
    bus.bkRvalid = 1'b1; bus.bkRdata = 32'h5555;
    step();
    bus.bkRvalid = 1'b0;
    step();
    check("stray_qvalid", 32'(bus.fsQValid), 32'd0);
    check("stray_q", bus.fsQ, 32'hDEAD_BEEF);

    // Read/write conflict
    clear_log();
    bus.fsRden = 1'b1; bus.fsWren = 1'b1; bus.fsAddress = 32'h50;
    #1;
    check("conf_busy", 32'(bus.fsBusy), 32'd0);
    step();
    bus.fsRden = 1'b0; bus.fsWren = 1'b0;
    check("conf_err", 32'(bus.fsErr), 32'd1);
    check("conf_bkvalid", 32'(bus.bkReqValid), 32'd0);
    step();
    check("conf_err_clr", 32'(bus.fsErr), 32'd0);
    check("conf_log", 32'(log_addr.size()), 32'd0);

    // Reset while waiting for read data
    bus.fsRden = 1'b1; bus.fsAddress = 32'h30;
    step();
    bus.fsRden = 1'b0;
    check("rstwait_rdreq", 32'(bus.bkReqValid), 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    check("rstwait_q", bus.fsQ, 32'd0);
    check("rstwait_fileSel", 32'(bus.fileSel), 32'd0);
    check("rstwait_bkvalid", 32'(bus.bkReqValid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    bus.bkRvalid = 1'b1; bus.bkRdata = 32'h1234;
    step();
    bus.bkRvalid = 1'b0;
    check("late_qvalid", 32'(bus.fsQValid), 32'd0);
    check("late_q", bus.fsQ, 32'd0);

    // Write in the commit cycle uses the newly opened file
    clear_log();
    chunk(C_DEV); chunk(C_MEM);
    bus.fsFilename = 32'd0; bus.fsWren = 1'b1; bus.fsAddress = 32'h40; bus.fsData = 32'h77;
    #1;
    check("bypass_busy", 32'(bus.fsBusy), 32'd0);
    step();
    bus.fsWren = 1'b0;
    check("bypass_err", 32'(bus.fsErr), 32'd0);
    check("bypass_fileSel", 32'(bus.fileSel), 32'd1);
    check("bypass_bkaddr", bus.bkAddr, 32'h40);
    check("bypass_bkfile", 32'(bus.bkFile), 32'd1);
    step();
    check("bypass_log", 32'(log_data.size()), 32'd1);

    // FSM back in IDLE after reset: a fresh read is accepted
    bus.fsRden = 1'b1; bus.fsAddress = 32'h40;
    #1;
    check("post_rst_rd_busy", 32'(bus.fsBusy), 32'd0);
    step();
    check("post_rst_rdreq_busy", 32'(bus.fsBusy), 32'd1);
    bus.fsRden = 1'b0;
    step();
    bus.bkRvalid = 1'b1; bus.bkRdata = 32'h77;
    step();
    bus.bkRvalid = 1'b0;
    check("post_rst_qvalid", 32'(bus.fsQValid), 32'd1);
    check("post_rst_q", bus.fsQ, 32'h77);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
